display_fetch_scheduler: RTL and testbench

- Sequences pixel fetches from the frame buffer ahead of raster timing and drives the display pixel/sync interface.
- Owns the raster counters and a small prefetch FIFO; issues one-at-a-time read requests with a req/ack handshake.
- Detects FIFO underflow and resynchronises at the next vertical blank.
- Sits between the frame buffer and the panel-side pixel output.

---
 rtl/display_fetch_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_display_fetch_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/display_fetch_scheduler.sv
// Raster timing generator with a small prefetch FIFO that pulls pixels from the
// frame buffer through a req/ack handshake and drives the panel pixel/sync interface.
module display_fetch_scheduler #(
  parameter int unsigned H_ACTIVE     = 800,
  parameter int unsigned H_TOTAL      = 1056,
  parameter int unsigned H_SYNC_START = 840,
  parameter int unsigned H_SYNC_LEN   = 128,
  parameter int unsigned V_ACTIVE     = 600,
  parameter int unsigned V_TOTAL      = 628,
  parameter int unsigned V_SYNC_START = 601,
  parameter int unsigned V_SYNC_LEN   = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ADDR_W       = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              fb_req,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic              fb_ack,
  input  logic [23:0]       fb_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              frame_start,
  output logic              underflow
);
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CW-1:0]     FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, PREFILL, RUN, DONE, RECOVER} state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [23:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic              frame_start_q, frame_start_d, underflow_q, underflow_d;
  logic [23:0]       rgb_q, rgb_d;

  logic        running, fetching, consuming, active, vblank_tick, go;
  logic        uflow, pop, push, last_ack, flush, h_wrap;
  logic [31:0] h32, v32;

  always_comb begin
    h32         = 32'(h_cnt_q);
    v32         = 32'(v_cnt_q);
    running     = state_q inside {RUN, DONE, RECOVER};
    fetching    = state_q inside {PREFILL, RUN};
    consuming   = state_q inside {RUN, DONE};
    go          = running && enable;
    active      = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    vblank_tick = (h32 == 0) && (v32 == V_ACTIVE);
    h_wrap      = (h_cnt_q == HW'(H_TOTAL - 1));

    fb_req   = fetching && (count_q < FULL);
    uflow    = enable && consuming && active && (count_q == '0);
    pop      = enable && consuming && active && (count_q != '0);
    // an ack landing on the underflow cycle is accepted but its pixel dropped
    push     = enable && fb_req && fb_ack && !uflow;
    last_ack = push && (fetch_addr_q == LAST_ADDR);

    state_d      = state_q;
    flush        = 1'b0;
    fetch_addr_d = fetch_addr_q;
    if (push) fetch_addr_d = last_ack ? '0 : fetch_addr_q + 1'b1;

    case (state_q)
      IDLE:    state_d = PREFILL;
      PREFILL: if (count_q == FULL) state_d = RUN;
      RUN: begin
        if (uflow)         state_d = RECOVER;
        else if (last_ack) state_d = DONE;
      end
      DONE: begin
        if (vblank_tick) begin
          state_d      = RUN;
          fetch_addr_d = '0;
        end else if (uflow) begin
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (vblank_tick) begin
          state_d      = RUN;
          flush        = 1'b1;
          fetch_addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d      = IDLE;
      flush        = 1'b1;
      fetch_addr_d = '0;
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // raster counters sit at the origin until the FIFO has been primed
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (go) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
    end

    de_d          = pop;
    rgb_d         = pop ? mem_q[rd_ptr_q] : '0;
    hsync_d       = go && (h32 >= H_SYNC_START) && (h32 < H_SYNC_START + H_SYNC_LEN);
    vsync_d       = go && (v32 >= V_SYNC_START) && (v32 < V_SYNC_START + V_SYNC_LEN);
    frame_start_d = go && (h32 == 0) && (v32 == 0) && (state_q != RECOVER);
    underflow_d   = enable && (underflow_q || uflow);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      fetch_addr_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      fetch_addr_q  <= fetch_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign fb_addr     = fetch_addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
endmodule

// File: tb/tb_display_fetch_scheduler.sv
// Directed-plus-random bench for display_fetch_scheduler on a tiny 12x6 raster;
// expected pixel stream and sync timing come from raster arithmetic and a pixel table.
module tb_display_fetch_scheduler;
  localparam int HA = 8, HT = 12, HSS = 9, HSL = 1;
  localparam int VA = 4, VT = 6, VSS = 5, VSL = 1;
  localparam int FD = 4, AW = 19, NPIX = HA * VA, FR = HT * VT;

  logic          clk = 1'b0;
  logic          rst, enable, fb_req, fb_ack;
  logic [AW-1:0] fb_addr;
  logic [23:0]   fb_data;
  logic          hsync, vsync, de, frame_start, underflow;
  logic [7:0]    r, g, b;
  logic [23:0]   pix_mem [NPIX];
  int            total = 0, bad = 0;

  display_fetch_scheduler #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
    .FIFO_DEPTH(FD), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fb_req(fb_req), .fb_addr(fb_addr),
    .fb_ack(fb_ack), .fb_data(fb_data), .hsync(hsync), .vsync(vsync), .de(de),
    .r(r), .g(g), .b(b), .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;
  always_comb fb_data = pix_mem[int'(fb_addr) % NPIX];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_pix();
    foreach (pix_mem[i]) pix_mem[i] = 24'($urandom);
  endtask

  // first four acks after (re)start must carry addresses 0..3 on back-to-back cycles
  task automatic collect_acks(input string tag);
    int got = 0, c0 = 0, seq_bad = 0;
    for (int j = 0; j < 30 && got < 4; j++) begin
      if (fb_req && fb_ack) begin
        if (int'(fb_addr) != got) seq_bad++;
        if (got == 0) c0 = j;
        else if (j != c0 + got) seq_bad++;
        got++;
      end
      tick();
    end
    chk({tag, " ack count"}, 64'(got), 64'd4);
    chk({tag, " ack seq"}, 64'(seq_bad), 64'd0);
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    while (!frame_start && n < 400) begin
      tick();
      n++;
    end
    chk({tag, " frame_start seen"}, 64'(frame_start), 64'd1);
  endtask

  // Starts on a frame_start sample; output index i maps to raster position h=i%HT, v=i/HT.
  task automatic observe_frame(input string tag, input int stall_at);
    int  de_n = 0, de_bad = 0, rgb_bad = 0, hs_bad = 0, vs_bad = 0, fs_n = 0;
    int  post_bad = 0, first_addr = -1, first_i = -1;
    bit  uf_seen = 0, exp_de, exp_hs, exp_vs;
    for (int i = 0; i < FR; i++) begin
      if (i == stall_at) fb_ack = 1'b0;
      if (stall_at >= 0 && i == stall_at + 10) fb_ack = 1'b1;
      exp_de = (i % HT < HA) && (i / HT < VA);
      exp_hs = (i % HT >= HSS) && (i % HT < HSS + HSL);
      exp_vs = (i / HT >= VSS) && (i / HT < VSS + VSL);
      if (hsync !== exp_hs) hs_bad++;
      if (vsync !== exp_vs) vs_bad++;
      if (frame_start === 1'b1) fs_n++;
      if (de === 1'b1) begin
        if (de_n >= NPIX || {r, g, b} !== pix_mem[de_n]) rgb_bad++;
        de_n++;
      end else if ({r, g, b} !== 24'd0) rgb_bad++;
      if (stall_at < 0 && de !== exp_de) de_bad++;
      if (stall_at >= 0 && de === 1'b1 && !exp_de) de_bad++;
      if (underflow === 1'b1) uf_seen = 1;
      if (stall_at >= 0 && uf_seen && de === 1'b1) post_bad++;
      if (stall_at >= 0 && uf_seen && first_addr < 0 && fb_req && fb_ack) begin
        first_addr = int'(fb_addr);
        first_i    = i;
      end
      tick();
    end
    chk({tag, " hsync timing"}, 64'(hs_bad), 64'd0);
    chk({tag, " vsync timing"}, 64'(vs_bad), 64'd0);
    chk({tag, " rgb stream"}, 64'(rgb_bad), 64'd0);
    chk({tag, " de placement"}, 64'(de_bad), 64'd0);
    chk({tag, " one frame_start"}, 64'(fs_n), 64'd1);
    chk({tag, " next frame_start"}, 64'(frame_start), 64'd1);
    if (stall_at < 0) begin
      chk({tag, " de count"}, 64'(de_n), 64'(NPIX));
    end else begin
      chk({tag, " underflow set"}, 64'(underflow), 64'd1);
      chk({tag, " partial de"}, 64'(de_n >= HA && de_n < NPIX), 64'd1);
      chk({tag, " de after underflow"}, 64'(post_bad), 64'd0);
      chk({tag, " refetch addr"}, 64'(first_addr), 64'd0);
      chk({tag, " refetch in vblank"}, 64'(first_i >= VA * HT), 64'd1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; fb_ack = 1'b1;
    rand_pix();
    repeat (3) tick();
    chk("reset outputs", 64'({fb_req, hsync, vsync, de, frame_start, underflow, r, g, b, fb_addr}), 64'd0);

    rst = 1'b0; enable = 1'b1;
    collect_acks("prefill");
    wait_fs("start");
    chk("first pixel with frame_start", 64'({de, r, g, b}), 64'({1'b1, pix_mem[0]}));
    observe_frame("frame1", -1);
    observe_frame("frame2", -1);
    observe_frame("stall", 13);
    observe_frame("post-stall", -1);
    chk("underflow sticky", 64'(underflow), 64'd1);

    // drop enable mid-line while a request is outstanding
    repeat ($urandom_range(0, 30)) tick();
    n = 0;
    while (!(fb_req && de) && n < 60) begin
      tick();
      n++;
    end
    chk("req+de found", 64'(fb_req && de), 64'd1);
    enable = 1'b0;
    tick();
    chk("disable outputs", 64'({fb_req, de, hsync, underflow, r, g, b}), 64'd0);
    repeat (5) tick();
    chk("idle no req", 64'(fb_req), 64'd0);
    rand_pix();
    enable = 1'b1;
    collect_acks("reenable");
    wait_fs("reenable");
    observe_frame("reenable frame", -1);

    // synchronous reset while an ack is landing
    repeat ($urandom_range(5, 40)) tick();
    n = 0;
    while (!fb_req && n < 60) begin
      tick();
      n++;
    end
    chk("req before rst", 64'(fb_req && fb_ack), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst outputs", 64'({fb_req, hsync, vsync, de, frame_start, underflow, r, g, b, fb_addr}), 64'd0);
    rand_pix();
    rst = 1'b0;
    collect_acks("post-rst");
    wait_fs("post-rst");
    observe_frame("post-rst frame", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
